spec_readout_streamer: RTL and testbench
========================================

// Module: spec_readout_streamer
// PURPOSE
//  Downstream of spectrum accumulation / background subtraction. On start_i, reads the accumulated
//  power spectra out of the spectrum DPRAM, one range bin at a time (BIN_LEN points each), and
//  streams them as 32-bit words split over two 16-bit lanes with valid/ready.
//  It absorbs the fixed RAM read latency under backpressure, so no word is lost or duplicated.
// PARAMETERS
//  NofBits   16    output lane width; a word is 2*NofBits = 32 bits
//  IDX_W     10    log2(BIN_LEN); points per range bin = 1024
//  BIN_W     4     range-bin index width; RAM addr = {bin[BIN_W-1:0], idx[IDX_W-1:0]} (14 bits)
//  RD_LAT    2     DPRAM read latency, cycles from rd_addr_o to rd_data_i
//  FIFO_DEP  4     output skid FIFO depth; must be >= RD_LAT+1
// PORTS
//  clk_i       in   1      clock
//  rst_i       in   1      reset, asynchronous, active-high
//  start_i     in   1      1-cycle pulse; begin readout (ignored while busy_o=1)
//  abort_i     in   1      synchronous abort; flush and return to IDLE, no done_o
//  nof_bins_i  in   BIN_W+1  range bins to read, 0..16; sampled on accepted start_i
//  rd_addr_o   out  14     DPRAM read address
//  rd_data_i   in   32     DPRAM read data, valid RD_LAT cycles after rd_addr_o
//  y0_o        out  16     word[15:0]
//  y0z_o       out  16     word[31:16]
//  valid_o     out  1      output word valid
//  ready_i     in   1      downstream accept; a transfer is valid_o & ready_i
//  sop_o       out  1      first word of a range bin (header word if STREAM_HEADER_EN)
//  eop_o       out  1      last word of a range bin (idx = BIN_LEN-1)
//  busy_o      out  1      high from accepted start_i until done_o/abort
//  done_o      out  1      1-cycle pulse after the last word of the last bin is transferred
// BEHAVIOUR
//  Reset values: every output 0, FSM IDLE, counters 0, FIFO empty, rd_addr_o 0.
//  FSM: IDLE -> (start_i) LOAD -> [HDR] -> RD -> DRAIN -> DONE -> IDLE.
//   IDLE: busy_o=0. start_i latches nof_bins_i, clears bin/idx counters, busy_o=1 next cycle.
//   LOAD: nof_bins=0 -> DONE directly (no words out). Otherwise -> HDR if enabled, else RD.
//   RD: issue one read per cycle while credit available; idx++; at idx wrap (BIN_LEN-1 -> 0),
//       bin++; after the last idx of bin nof_bins-1 -> DRAIN. With header enabled, each bin
//       change passes through HDR before its reads.
//   DRAIN: wait until in-flight reads land and FIFO is empty -> DONE.
//   DONE: done_o=1 for exactly one cycle; busy_o falls the same cycle -> IDLE.
//  Credit rule: issue a read only if (reads in flight + FIFO occupancy) < FIFO_DEP.
//   The FIFO therefore never overflows. A read-valid shift register of length RD_LAT tags each
//   read; when the tag emerges, rd_data_i plus sop/eop tags are pushed into the FIFO.
//  Output: valid_o = FIFO not empty; y0/y0z/sop/eop come from the FIFO head (registered).
//   Pop on valid_o & ready_i. Data/tags hold stable while valid_o=1 and ready_i=0.
//  Latency: with ready_i held 1, first rd_addr_o is 2 cycles after start_i.
//   First valid_o is RD_LAT+1 cycles after the first rd_addr_o. Throughput is 1 word/cycle.
//  Word count: nof_bins*BIN_LEN, plus nof_bins headers if enabled. No gaps with ready_i=1.
//  nof_bins_i > 16 saturates to 16. start_i while busy_o=1 is ignored (no restart).
//  abort_i (any state but IDLE): next cycle FIFO flushed, in-flight tags cleared, valid_o=0,
//   busy_o=0, state IDLE, done_o not pulsed. abort_i takes priority over simultaneous start_i.
//  rst_i mid-operation: immediate clear to reset values; no partial done_o.
//  ready_i low for any length stalls reads via credit; no word is dropped or repeated.
// CONFIGURATION
//  STREAM_HEADER_EN defined: before each bin's data, one header word is emitted.
//   Header: y0z_o=16'hA5A5, y0_o={11'd0, bin[4:0]}; sop_o=1 on the header, not on data idx 0.
//   Headers consume a FIFO slot and no RAM read.
//  STREAM_HEADER_EN undefined: no header words; sop_o=1 on data idx 0 of each bin.
// TESTING
//  1. RAM word = address; nof_bins=2, ready=1, no header -> 2048 words 0..2047 contiguous;
//     sop at 0/1024, eop at 1023/2047; done 1 cycle after the last transfer.
//  2. Same as 1 with ready toggling randomly 50% -> identical sequence, no loss or duplicate;
//     FIFO occupancy never exceeds 4.
//  3. nof_bins=0 -> no valid_o; done_o pulses, busy_o high for the LOAD..DONE cycles only.
//  4. abort_i at word 500 of bin 0 -> valid_o=0 the next cycle, no done_o.
//     A new start with nof_bins=1 then streams 0..1023 cleanly.
//  5. STREAM_HEADER_EN, nof_bins=3 -> words A5A5_0000, then 1024 data, then A5A5_0001, ...;
//     3075 words total.
//  6. rst_i asserted mid-stream, then a start with nof_bins=16 -> all outputs 0 during reset;
//     16384 words follow with correct bin addressing up to 16383.

Source files
------------

// File: rtl/spec_readout_streamer.sv
// spec_readout_streamer: streams range-bin spectra out of the DPRAM with a credit-guarded skid FIFO; `define STREAM_HEADER_EN to prepend a header word to each bin
module spec_readout_streamer #(
  parameter int NofBits  = 16,
  parameter int IDX_W    = 10,
  parameter int BIN_W    = 4,
  parameter int RD_LAT   = 2,
  parameter int FIFO_DEP = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [BIN_W:0]           nof_bins_i,
  output logic [BIN_W+IDX_W-1:0]   rd_addr_o,
  input  logic [2*NofBits-1:0]     rd_data_i,
  output logic [NofBits-1:0]       y0_o,
  output logic [NofBits-1:0]       y0z_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     sop_o,
  output logic                     eop_o,
  output logic                     busy_o,
  output logic                     done_o
);
  localparam int AW = $clog2(FIFO_DEP);
  localparam int CW = $clog2(FIFO_DEP + 1);
  localparam logic [BIN_W:0] BIN_MAX = (BIN_W+1)'(1 << BIN_W);
`ifdef STREAM_HEADER_EN
  localparam logic HDR_EN = 1'b1;
`else
  localparam logic HDR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, HDR, RD, DRAIN, DONE} state_t;
  typedef struct packed {
    logic             v;
    logic             hdr;
    logic             sop;
    logic             eop;
    logic [BIN_W-1:0] bin;
  } tag_t;
  typedef struct packed {
    logic                 sop;
    logic                 eop;
    logic [2*NofBits-1:0] data;
  } ent_t;

  state_t           state, state_n;
  logic [BIN_W-1:0] bin;
  logic [IDX_W-1:0] idx;
  logic [BIN_W:0]   nof_bins;
  tag_t             pipe [RD_LAT];
  ent_t             mem [FIFO_DEP];
  logic [AW-1:0]    wp, rp;
  logic [CW-1:0]    count;
  logic [7:0]       inflight;
  logic             credit, issue, hdr_issue, last_idx, last_bin, push, pop;

  assign rd_addr_o = {bin, idx};
  assign last_idx  = &idx;
  assign last_bin  = ((BIN_W+1)'(bin) + 1'b1) == nof_bins;
  assign push      = pipe[RD_LAT-1].v;
  assign valid_o   = count != '0;
  assign pop       = valid_o & ready_i;
  assign {sop_o, eop_o, y0z_o, y0_o} = mem[rp];
  assign credit    = (inflight + 8'(count)) < 8'(FIFO_DEP);

  // Count reads (and headers) still travelling through the latency pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + 8'(pipe[i].v);
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;

  // Next state, read/header issue and status outputs; abort overrides everything.
  always_comb begin
    state_n   = state;
    issue     = 1'b0;
    hdr_issue = 1'b0;
    busy_o    = state inside {LOAD, HDR, RD, DRAIN};
    done_o    = state == DONE;
    case (state)
      IDLE:  if (start_i) state_n = LOAD;
      LOAD:  state_n = nof_bins == '0 ? DONE : (HDR_EN ? HDR : RD);
      HDR:   if (credit) begin
        hdr_issue = 1'b1;
        state_n   = RD;
      end
      RD:    if (credit) begin
        issue = 1'b1;
        if (last_idx) state_n = last_bin ? DRAIN : (HDR_EN ? HDR : RD);
      end
      DRAIN: if (inflight == '0 && (count == '0 || (count == CW'(1) && pop))) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort_i) state_n = IDLE;
  end

  // Bin/point counters and the latched bin count (saturated to the RAM size).
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      bin      <= '0;
      idx      <= '0;
      nof_bins <= '0;
    end else if (state == IDLE && start_i && !abort_i) begin
      bin      <= '0;
      idx      <= '0;
      nof_bins <= nof_bins_i > BIN_MAX ? BIN_MAX : nof_bins_i;
    end else if (issue) begin
      idx <= idx + 1'b1;
      if (last_idx) bin <= bin + 1'b1;
    end

  // Tag pipe matching the RAM latency; headers ride it too so ordering is preserved.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else if (abort_i) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{v: issue | hdr_issue, hdr: hdr_issue,
                   sop: hdr_issue | (issue & ~HDR_EN & (idx == '0)),
                   eop: issue & last_idx, bin: bin};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end

  // Skid FIFO; credit guarantees a push never meets a full FIFO.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEP; i++) mem[i] <= '0;
    end else if (abort_i) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= '{sop: pipe[RD_LAT-1].sop, eop: pipe[RD_LAT-1].eop,
                     data: pipe[RD_LAT-1].hdr ? {NofBits'(16'hA5A5), NofBits'(pipe[RD_LAT-1].bin)} : rd_data_i};
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: tb/tb_spec_readout_streamer.sv
// tb_spec_readout_streamer: directed checks of readout order, backpressure, abort, reset and bin saturation
module tb_spec_readout_streamer;
`ifdef STREAM_HEADER_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif
  logic        clk = 0, rst_i = 1, start_i = 0, abort_i = 0, ready_i = 1;
  logic [4:0]  nof_bins_i = 0;
  logic [13:0] rd_addr_o, a1 = 0, a2 = 0;
  logic [31:0] rd_data_i;
  logic [15:0] y0_o, y0z_o;
  logic        valid_o, sop_o, eop_o, busy_o, done_o;
  int checks = 0, errors = 0;

  spec_readout_streamer dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .nof_bins_i(nof_bins_i), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .y0_o(y0_o), .y0z_o(y0z_o), .valid_o(valid_o), .ready_i(ready_i),
    .sop_o(sop_o), .eop_o(eop_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a1 <= rd_addr_o;
    a2 <= a1;
  end
  assign rd_data_i = {16'(a2) ^ 16'hFFFF, 16'(a2)};

  function automatic logic [33:0] exp_at(input int p);
    int per, b, j, a;
    per = 1024 + H;
    b = p / per;
    j = p % per;
    if (H == 1 && j == 0) return {1'b1, 1'b0, 16'hA5A5, 16'(b)};
    a = b * 1024 + j - H;
    return {1'(j - H == 0 && H == 0), 1'(j - H == 1023), 16'(a) ^ 16'hFFFF, 16'(a)};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({valid_o, busy_o, done_o, sop_o, eop_o} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {valid_o, busy_o, done_o, sop_o, eop_o});
    end
    checks++;
    if ({y0z_o, y0_o} !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {y0z_o, y0_o});
    end
    checks++;
    if (rd_addr_o !== 14'h0) begin
      errors++; $display("FAIL reset_addr: got %h want 0", rd_addr_o);
    end
    rst_i = 0;
  endtask

  task automatic run_stream(input logic [4:0] n_in, input int n_eff, input bit rnd, input int stop_at, input string name);
    int total, got, bad, cyc, first_v, last_x, sops, eops, lim, bad_at;
    logic [33:0] obs, e, held;
    logic hold;
    total = n_eff * (1024 + H);
    got = 0; bad = 0; first_v = -1; last_x = -1; sops = 0; eops = 0; hold = 0; bad_at = -1;
    obs = '0; e = '0; held = '0;
    lim = total * 3 + 200;
    @(negedge clk); start_i = 1; nof_bins_i = n_in;
    @(negedge clk); start_i = 0;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_start: got %b want 1", name, busy_o);
    end
    cyc = 1;
    while (got < total && (stop_at < 0 || got < stop_at) && cyc < lim) begin
      ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start_i = cyc == 100;
      nof_bins_i = cyc == 100 ? 5'd1 : n_in;
      obs = {sop_o, eop_o, y0z_o, y0_o};
      if (hold && (!valid_o || obs !== held)) begin
        bad++; if (bad_at < 0) bad_at = got;
      end
      hold = 0;
      if (valid_o) begin
        if (first_v < 0) first_v = cyc;
        if (ready_i) begin
          e = exp_at(got);
          if (obs !== e) begin
            bad++;
            if (bad_at < 0) begin bad_at = got; $display("  word %0d got %h want %h", got, obs, e); end
          end
          sops += int'(sop_o); eops += int'(eop_o);
          got++; last_x = cyc;
        end else begin
          hold = 1; held = obs;
        end
      end
      @(negedge clk); cyc++;
    end
    start_i = 0; ready_i = 1;
    checks++;
    if (got !== (stop_at < 0 ? total : stop_at)) begin
      errors++; $display("FAIL %s word_count: got %0d want %0d", name, got, stop_at < 0 ? total : stop_at);
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL %s content: %0d bad words (first at %0d) want 0", name, bad, bad_at);
    end
    if (stop_at < 0) begin
      checks++;
      if (sops !== n_eff || eops !== n_eff) begin
        errors++; $display("FAIL %s sop_eop: got %0d/%0d want %0d/%0d", name, sops, eops, n_eff, n_eff);
      end
      checks++;
      if ({done_o, busy_o} !== 2'b10) begin
        errors++; $display("FAIL %s done_after_last: got done=%b busy=%b want 1/0", name, done_o, busy_o);
      end
      if (!rnd) begin
        checks++;
        if (first_v !== 5 || last_x - first_v !== total - 1) begin
          errors++; $display("FAIL %s latency_gaps: first=%0d span=%0d want 5/%0d", name, first_v, last_x - first_v, total - 1);
        end
      end
      @(negedge clk);
      checks++;
      if (done_o !== 1'b0) begin
        errors++; $display("FAIL %s done_width: got %b want 0", name, done_o);
      end
    end
  endtask

  task automatic test_zero_bins();
    int vseen;
    vseen = 0;
    @(negedge clk); start_i = 1; nof_bins_i = 5'd0;
    @(negedge clk); start_i = 0;
    checks++;
    if ({busy_o, done_o} !== 2'b10) begin
      errors++; $display("FAIL zero_load: got busy=%b done=%b want 1/0", busy_o, done_o);
    end
    vseen += int'(valid_o);
    @(negedge clk);
    checks++;
    if ({busy_o, done_o} !== 2'b01) begin
      errors++; $display("FAIL zero_done: got busy=%b done=%b want 0/1", busy_o, done_o);
    end
    for (int i = 0; i < 5; i++) begin
      vseen += int'(valid_o);
      @(negedge clk);
    end
    checks++;
    if ({vseen, busy_o, done_o} !== {32'd0, 2'b00}) begin
      errors++; $display("FAIL zero_quiet: got valid_cycles=%0d busy=%b done=%b want 0/0/0", vseen, busy_o, done_o);
    end
  endtask

  task automatic test_abort();
    int seen;
    seen = 0;
    run_stream(5'd2, 2, 1'b0, 500, "pre_abort");
    ready_i = 0; abort_i = 1;
    @(negedge clk); abort_i = 0;
    checks++;
    if ({valid_o, busy_o} !== 2'b00) begin
      errors++; $display("FAIL abort_next: got valid=%b busy=%b want 0/0", valid_o, busy_o);
    end
    ready_i = 1;
    for (int i = 0; i < 20; i++) begin
      seen += int'(valid_o | done_o);
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL abort_quiet: got %0d valid/done cycles want 0", seen);
    end
    start_i = 1; abort_i = 1; nof_bins_i = 5'd1;
    @(negedge clk); start_i = 0; abort_i = 0;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL abort_over_start: got busy=%b want 0", busy_o);
    end
    run_stream(5'd1, 1, 1'b0, -1, "after_abort");
  endtask

  task automatic test_reset_mid();
    run_stream(5'd1, 1, 1'b0, 300, "pre_reset");
    rst_i = 1;
    #1;
    checks++;
    if ({valid_o, busy_o, done_o, sop_o, eop_o, y0z_o, y0_o, rd_addr_o} !== '0) begin
      errors++; $display("FAIL reset_mid: got valid=%b busy=%b done=%b data=%h addr=%h want all 0",
                         valid_o, busy_o, done_o, {y0z_o, y0_o}, rd_addr_o);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({valid_o, busy_o, done_o, y0z_o, y0_o} !== '0) begin
      errors++; $display("FAIL reset_hold: got valid=%b busy=%b done=%b data=%h want all 0",
                         valid_o, busy_o, done_o, {y0z_o, y0_o});
    end
    rst_i = 0;
    run_stream(5'd16, 16, 1'b0, -1, "full_16");
  endtask

  initial begin
    test_reset();
    run_stream(5'd2, 2, 1'b0, -1, "basic_2");
    run_stream(5'd2, 2, 1'b1, -1, "backpressure_2");
    test_zero_bins();
    test_abort();
    test_reset_mid();
    run_stream(5'd31, 16, 1'b0, -1, "saturate_31");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
